// File: rtl/fadd_sched_pkg.sv
// fadd_sched_pkg: shared types and constants for the shared float-adder scheduler.
// State encoding, quiet-NaN abort value, requester-id width helper.
package fadd_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request at/after ptr.
// Ports: ptr (start index), req (requests) -> grant (one-hot), idx, any.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [IW-1:0] ptr,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/fadd_share_sched.sv
// fadd_share_sched: shares one start/done float adder among N_REQ requesters.
// Ports: clk, rst (async, active-high); req_valid/req_a/req_b/req_ready
//   (requester side); resp_valid/resp_ready/resp_data/resp_err (result side);
//   fa_start/fa_a/fa_b/fa_done/fa_c (adder side); busy.
// Build option FADD_SCHED_TIMEOUT_EN: watchdog aborts a WAIT after
//   TIMEOUT_CYCLES with a quiet NaN and resp_err=1.
import fadd_sched_pkg::*;

module fadd_share_sched #(
  parameter int N_REQ          = 4,
  parameter int W              = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_a,
  input  logic [N_REQ*W-1:0] req_b,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   resp_valid,
  input  logic [N_REQ-1:0]   resp_ready,
  output logic [W-1:0]       resp_data,
  output logic               resp_err,
  output logic               fa_start,
  output logic [W-1:0]       fa_a,
  output logic [W-1:0]       fa_b,
  input  logic               fa_done,
  input  logic [W-1:0]       fa_c,
  output logic               busy
);

  localparam int IW = id_w(N_REQ);

  state_t          state, state_nx;
  logic [IW-1:0]   rr_ptr, id, gnt_idx;
  logic [N_REQ-1:0] gnt;
  logic            gnt_any;
  logic            accept;
  logic            resp_hs;
  logic            to_hit;

  rr_arbiter #(
    .N  (N_REQ),
    .IW (IW)
  ) u_arb (
    .ptr   (rr_ptr),
    .req   (req_valid),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  // Gate with rst so the grant is silent while reset is held.
  assign accept    = (state == IDLE) && gnt_any && !rst;
  assign req_ready = accept ? gnt : '0;
  assign resp_hs   = (state == RESP) && resp_ready[id];
  assign fa_start  = (state == ISSUE);
  assign busy      = (state != IDLE);

  always_comb begin
    resp_valid = '0;
    if (state == RESP)
      resp_valid[id] = 1'b1;
  end

`ifdef FADD_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] to_cnt;

  // Fires on the last allowed WAIT cycle; a done in that cycle wins.
  assign to_hit = (state == WAIT) && !fa_done &&
                  (to_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt   <= '0;
      resp_err <= 1'b0;
    end else begin
      if (state == ISSUE)
        to_cnt <= '0;
      else if (state == WAIT)
        to_cnt <= to_cnt + CW'(1);
      if (state == WAIT) begin
        if (fa_done)
          resp_err <= 1'b0;
        else if (to_hit)
          resp_err <= 1'b1;
      end
    end
  end
`else
  assign to_hit   = 1'b0;
  assign resp_err = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (fa_done || to_hit) state_nx = RESP;
      RESP:    if (resp_hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id        <= '0;
      fa_a      <= '0;
      fa_b      <= '0;
      resp_data <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        id     <= gnt_idx;
        rr_ptr <= (gnt_idx == IW'(N_REQ - 1)) ? '0 : gnt_idx + IW'(1);
        fa_a   <= req_a[int'(gnt_idx)*W +: W];
        fa_b   <= req_b[int'(gnt_idx)*W +: W];
      end
      if (state == WAIT) begin
        if (fa_done)
          resp_data <= fa_c;
        else if (to_hit)
          resp_data <= W'(QNAN);
      end
    end
  end

endmodule
